// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC update scheduler: FSM states,
// DAC port widths and the idle levels of the DAC control pins.
package dac_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } dac_state_e;

    localparam int DAC_ADDR_W = 5;
    localparam int DAC_DATA_W = 16;

    localparam logic CS_N_IDLE  = 1'b1;
    localparam logic RE_WR_IDLE = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, with wrap.
// The pointer register is owned by the parent.
module rr_arbiter #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_vld
);

    logic [CH_W-1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            idx = CH_W'((int'(ptr) + off) % NUM_CH);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_update_scheduler.sv
// Shadows per-channel DAC values and drives them out round-robin through a
// setup/strobe/hold parallel write cycle. Optional DAC_LDAC_EN adds dac_ldac_n.
module dac_update_scheduler
    import dac_sched_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  upd_we,
    input  logic [CH_W-1:0]       upd_ch,
    input  logic [15:0]           upd_data,
    input  logic                  enable,
    output logic [NUM_CH-1:0]     pending,
    output logic                  busy,
    output logic                  xfer_done,
    output logic                  dac_re_wr,
    output logic                  dac_cs_n,
    output logic [DAC_ADDR_W-1:0] dac_add,
    output logic [DAC_DATA_W-1:0] dac_data
`ifdef DAC_LDAC_EN
    ,
    output logic                  dac_ldac_n
`endif
);

    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    dac_state_e                state;
    logic [CNT_W-1:0]          cnt;
    logic [CH_W-1:0]           ptr;
    logic [DAC_DATA_W-1:0]     shadow [NUM_CH];
    logic [NUM_CH-1:0]         pending_nxt;
    logic [CH_W-1:0]           gnt_idx;
    logic                      gnt_vld;
    logic                      grant_fire;
    logic                      upd_ok;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req     (pending),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign upd_ok     = upd_we && (int'(upd_ch) < NUM_CH);
    assign grant_fire = (state == ST_IDLE) && enable && gnt_vld;

    // Set after clear: an update landing on the grant edge stays pending.
    always_comb begin
        pending_nxt = pending;
        if (grant_fire) pending_nxt[gnt_idx] = 1'b0;
        if (upd_ok)     pending_nxt[upd_ch]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ptr       <= CH_W'(NUM_CH - 1);
            pending   <= '0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
            dac_cs_n  <= CS_N_IDLE;
            dac_re_wr <= RE_WR_IDLE;
            dac_add   <= '0;
            dac_data  <= '0;
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else begin
            pending   <= pending_nxt;
            xfer_done <= 1'b0;
            if (upd_ok) shadow[upd_ch] <= upd_data;
            case (state)
                ST_IDLE: begin
                    if (grant_fire) begin
                        ptr       <= gnt_idx;
                        dac_add   <= DAC_ADDR_W'(gnt_idx);
                        dac_data  <= shadow[gnt_idx];
                        dac_re_wr <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= CNT_W'(SETUP_CYC - 1);
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        dac_cs_n <= 1'b0;
                        cnt      <= CNT_W'(STROBE_CYC - 1);
                        state    <= ST_STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        dac_cs_n  <= CS_N_IDLE;
                        cnt       <= CNT_W'(HOLD_CYC - 1);
                        xfer_done <= (HOLD_CYC == 1);
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        dac_re_wr <= RE_WR_IDLE;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        cnt       <= cnt - 1'b1;
                        xfer_done <= (cnt == CNT_W'(1));
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DAC_LDAC_EN
    // Load strobe in the idle cycle that closes a batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_ldac_n <= 1'b1;
        end else begin
            dac_ldac_n <= !((state == ST_HOLD) && (cnt == '0) && (pending_nxt == '0));
        end
    end
`endif

endmodule
